// File: rtl/elevator_call_register.sv
// elevator_call_register: latches hall/car button presses and clears the calls served after a door dwell.
// Optional PHANTOM_BTN_MASK_EN removes the nonexistent U4 and D1 hall buttons.
module elevator_call_register #(
  parameter int DWELL_CYCLES = 8,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] btn_u,
  input  logic [3:0] btn_d,
  input  logic [3:0] btn_f,
  input  logic [3:0] sens,
  input  logic       up,
  input  logic       down,
  input  logic       stop,
  output logic [3:0] call_u,
  output logic [3:0] call_d,
  output logic [3:0] call_f,
  output logic [1:0] floor,
  output logic       any_call,
  output logic       served
);
  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;
  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [3:0]       r_sens, r_call_u, r_call_d, r_call_f;
  logic [3:0]       w_mask_u, w_mask_d, w_floor_oh, w_clr_u, w_clr_d, w_clr_f;
  logic [1:0]       r_floor, w_idx;
  logic             r_last_dir, w_valid, w_last, w_served, w_chg, w_others;
`ifdef PHANTOM_BTN_MASK_EN
  assign w_mask_u = 4'b0111;
  assign w_mask_d = 4'b1110;
`else
  assign w_mask_u = 4'b1111;
  assign w_mask_d = 4'b1111;
`endif
  assign w_valid    = $onehot(sens);
  assign w_idx      = sens[3] ? 2'd3 : sens[2] ? 2'd2 : sens[1] ? 2'd1 : 2'd0;
  assign w_last     = r_cnt == CNT_W'(DWELL_CYCLES - 1);
  assign w_served   = (r_state == DWELL) && w_last;
  assign w_chg      = sens != r_sens;
  assign w_floor_oh = 4'b0001 << r_floor;
  // a lone call at this floor is answered in both directions
  assign w_others   = |((r_call_u | r_call_d | r_call_f) & ~w_floor_oh);
  assign w_clr_f    = w_served ? w_floor_oh : 4'b0000;
  assign w_clr_u    = (w_served && (r_last_dir || r_floor == 2'd0 || !w_others)) ? w_floor_oh : 4'b0000;
  assign w_clr_d    = (w_served && (!r_last_dir || r_floor == 2'd3 || !w_others)) ? w_floor_oh : 4'b0000;
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_nx   = '0;
        w_state_nx = (stop && w_valid) ? DWELL : IDLE;
      end
      DWELL: begin
        w_state_nx = w_last ? DONE : (!stop || w_chg) ? IDLE : DWELL;
        w_cnt_nx   = w_last ? r_cnt : (!stop || w_chg) ? '0 : r_cnt + CNT_W'(1);
      end
      DONE: begin
        w_state_nx = (!stop || w_chg) ? IDLE : DONE;
        w_cnt_nx   = (!stop || w_chg) ? '0 : r_cnt;
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sens     <= '0;
      r_floor    <= '0;
      r_last_dir <= 1'b1;
      r_call_u   <= '0;
      r_call_d   <= '0;
      r_call_f   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_sens   <= (r_state == IDLE) ? sens : r_sens;
      r_floor  <= w_valid ? w_idx : r_floor;
      r_last_dir <= (up && !down) ? 1'b1 : (down && !up) ? 1'b0 : r_last_dir;
      r_call_u <= ((r_call_u & ~w_clr_u) | btn_u) & w_mask_u;
      r_call_d <= ((r_call_d & ~w_clr_d) | btn_d) & w_mask_d;
      r_call_f <= (r_call_f & ~w_clr_f) | btn_f;
    end
  end
  assign call_u   = r_call_u;
  assign call_d   = r_call_d;
  assign call_f   = r_call_f;
  assign floor    = r_floor;
  assign any_call = |{r_call_u, r_call_d, r_call_f};
  assign served   = w_served;
endmodule

// File: tb/tb_elevator_call_register.sv
// tb_elevator_call_register: random stimulus against a per-floor call model with a queued scoreboard.
module tb_elevator_call_register;
  localparam int D = 8;
  logic clk = 1'b0, reset_n;
  logic [3:0] btn_u, btn_d, btn_f, sens, call_u, call_d, call_f;
  logic up, down, stop, any_call, served;
  logic [1:0] floor;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [3:0] u, d, f;
    logic [1:0] fl;
    logic any, srv;
  } exp_t;
  exp_t q[$];
  bit m_u[4], m_d[4], m_f[4];
  int m_floor, m_dir, ph, start, e;
  logic [3:0] ssens;
  elevator_call_register #(.DWELL_CYCLES(D), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .btn_u(btn_u), .btn_d(btn_d), .btn_f(btn_f),
    .sens(sens), .up(up), .down(down), .stop(stop), .call_u(call_u), .call_d(call_d),
    .call_f(call_f), .floor(floor), .any_call(any_call), .served(served)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int x);
    n_cmp++;
    if (a != x) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_u[k] = 0; m_d[k] = 0; m_f[k] = 0;
    end
    m_floor = 0; m_dir = 1; ph = 0; start = 0;
  endtask
  task automatic check_reset_outputs();
    chk("rst_call_u", int'(call_u), 0);
    chk("rst_call_d", int'(call_d), 0);
    chk("rst_call_f", int'(call_f), 0);
    chk("rst_floor", int'(floor), 0);
    chk("rst_any", int'(any_call), 0);
    chk("rst_served", int'(served), 0);
  endtask
  // one clock edge of the reference behaviour; returns the expected post-edge outputs
  task automatic model_step(output exp_t x);
    bit others, one;
    int idx, k;
    logic [3:0] bu, bd;
    e++;
    if (ph == 1 && e - start == D) begin
      k = m_floor;
      others = 0;
      for (int j = 0; j < 4; j++) if (j != k && (m_u[j] || m_d[j] || m_f[j])) others = 1;
      m_f[k] = 0;
      if (m_dir == 1 || k == 0 || !others) m_u[k] = 0;
      if (m_dir == 0 || k == 3 || !others) m_d[k] = 0;
      ph = 2;
    end else if (ph == 1 || ph == 2) begin
      if (!stop || sens != ssens) ph = 0;
    end else if (stop && $countones(sens) == 1) begin
      ph = 1; start = e; ssens = sens;
    end
    bu = btn_u; bd = btn_d;
`ifdef PHANTOM_BTN_MASK_EN
    bu[3] = 1'b0; bd[0] = 1'b0;
`endif
    one = $countones(sens) == 1;
    idx = 0;
    for (int j = 0; j < 4; j++) begin
      if (bu[j]) m_u[j] = 1;
      if (bd[j]) m_d[j] = 1;
      if (btn_f[j]) m_f[j] = 1;
      if (sens[j]) idx = j;
    end
    if (one) m_floor = idx;
    if (up && !down) m_dir = 1;
    if (down && !up) m_dir = 0;
    for (int j = 0; j < 4; j++) begin
      x.u[j] = m_u[j]; x.d[j] = m_d[j]; x.f[j] = m_f[j];
    end
    x.fl = 2'(m_floor);
    x.any = |{x.u, x.d, x.f};
    x.srv = (ph == 1) && (e + 1 - start == D);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("call_u", int'(call_u), int'(x.u));
      chk("call_d", int'(call_d), int'(x.d));
      chk("call_f", int'(call_f), int'(x.f));
      chk("floor", int'(floor), int'(x.fl));
      chk("any_call", int'(any_call), int'(x.any));
      chk("served", int'(served), int'(x.srv));
    end
  end
  initial begin
    exp_t x;
    int hold = 0, r;
    logic cur_stop = 1'b0;
    logic [3:0] cur_sens = 4'b0001;
    reset_n = 1'b0;
    {btn_u, btn_d, btn_f, sens, up, down, stop} = '0;
    e = 0;
    model_reset();
    #2 check_reset_outputs();
    #1 reset_n = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        #5 reset_n = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        #1 reset_n = 1'b1;
      end
      if (hold == 0) begin
        hold = $urandom_range(1, 14);
        cur_stop = $urandom_range(0, 3) != 0;
        r = $urandom_range(0, 9);
        cur_sens = (r < 7) ? (4'b0001 << $urandom_range(0, 3)) : (r == 7) ? 4'b0000 : 4'($urandom_range(0, 15));
      end
      hold--;
      for (int j = 0; j < 4; j++) begin
        btn_u[j] = $urandom_range(0, 11) == 0;
        btn_d[j] = $urandom_range(0, 11) == 0;
        btn_f[j] = $urandom_range(0, 11) == 0;
      end
      r = $urandom_range(0, 3);
      up = r == 0 || r == 2;
      down = r == 1 || r == 2;
      stop = cur_stop;
      sens = cur_sens;
      model_step(x);
      @(posedge clk);
      q.push_back(x);
      #1;
    end
    @(posedge clk);
    #6;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/elevator_call_register.md
# elevator_call_register

Request-latching stage directly upstream of the 4-floor elevator controller. It captures momentary hall-button (U1..D4) and car-button (F1..F4) presses into held call bits and presents them as steady levels to the controller's button inputs. It monitors floor sensors and the controller's motor outputs, times a door-dwell interval, and clears the calls served at the stopped floor when that interval ends.

## Interface
Parameters:
- DWELL_CYCLES, 8, cycles the car must sit stopped at one floor before its calls clear (legal range 2..15).
- CNT_W, 4, width of the dwell counter; must satisfy 2^CNT_W > DWELL_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- btn_u  in  4  raw up-call buttons; bit k-1 is floor k (U1..U4).
- btn_d  in  4  raw down-call buttons, same bit mapping (D1..D4).
- btn_f  in  4  raw car buttons, same bit mapping (F1..F4).
- sens  in  4  floor sensors S1..S4; bit k-1 is floor k.
- up, down, stop  in  1 each  motor state fed back from the controller.
- call_u, call_d, call_f  out  4 each  latched calls, driven to the controller's U/D/F inputs.
- floor  out  2  last valid floor (0 = floor 1 … 3 = floor 4).
- any_call  out  1  OR of all latched call bits (combinational from the registers).
- served  out  1  one-cycle pulse on the cycle the calls at the current floor clear.

## Operation
- Set: a button bit high on a rising clk sets the matching call bit on that edge. Setting is level-based, so a held button keeps its bit set.
- Valid floor: exactly one sens bit high. `floor` updates to that index on every cycle where the floor is valid. Zero or multiple active sensors leave `floor` unchanged.
- Direction register `last_dir` (1 = up): set to 1 when up=1 and to 0 when down=1. If both are 1, `last_dir` holds its value.
- Dwell FSM, states IDLE, DWELL, DONE:
  - IDLE: counter = 0. Go to DWELL when stop=1 and the floor is valid.
  - DWELL: the counter increments each cycle. Return to IDLE and zero the counter if stop=0, the floor becomes invalid, or the active sensor changes. When the counter equals DWELL_CYCLES-1, assert `served` for that cycle, apply the clear, and go to DONE.
  - DONE: the counter holds. Go to IDLE when stop=0 or the sensor changes. No further clear occurs while in DONE.
- Clear at floor k (applied in the served cycle):
  - call_f[k] is always cleared.
  - call_u[k] is cleared if last_dir=1 or k=1.
  - call_d[k] is cleared if last_dir=0 or k=4.
  - If no call bit at any other floor is set, both call_u[k] and call_d[k] are cleared.
- Simultaneous set and clear on the same bit in the same cycle: set wins and the bit stays 1.
- Reset mid-operation clears every call immediately; no partial clear is applied.

## Timing
- Reset values: call_u = call_d = call_f = 0, floor = 0, last_dir = 1, FSM = IDLE, counter = 0, served = 0, any_call = 0.
- Button to call bit: 1 cycle latency, registered on the first rising edge with the button high.
- `any_call` follows the call registers combinationally, with no extra latency.
- Stop-to-clear: if stop=1 and sensor k are stable from edge n (IDLE→DWELL on edge n), `served` is high in the cycle after edge n+DWELL_CYCLES-1, and the call bits drop on edge n+DWELL_CYCLES.
- `served` is exactly one cycle wide per stop. Re-arming requires stop=0 or a change of sensor.
- No combinational path from any input to call_* or served.

## Configuration
- PHANTOM_BTN_MASK_EN:
  - Defined: btn_u[3] (U4) and btn_d[0] (D1) are ignored, and call_u[3] and call_d[0] are constant 0. Their direction-clear terms are irrelevant.
  - Undefined: these bits latch and clear exactly like every other button. Reset default is undefined.

## Test plan
- Reset: reset_n=0 asynchronously mid-cycle with calls set → all call_* = 0, floor = 0, served = 0 immediately.
- Latching: pulse btn_f[2] for 1 cycle → call_f = 4'b0100 from the next edge and held; any_call = 1.
- Service at floor 3, going up: set call_u[2], call_d[2], call_f[2], and call_f[3]; drive last_dir=1 via up=1, then stop=1, sens=4'b0100 for 8 cycles → served pulses once. call_f[2] and call_u[2] clear; call_d[2] and call_f[3] remain.
- Lone-call clear: only call_d[1] set; stop at floor 2 with last_dir=1 → after the dwell, call_d[1] = 0 and any_call = 0.
- Interrupted dwell: stop=1 at floor 2 for 5 cycles, then stop=0, then stop=1 again → no clear at cycle 5; served occurs 8 cycles after the restart.
- Set/clear collision: btn_f[1] high on the served cycle at floor 2 → call_f[1] remains 1. With PHANTOM_BTN_MASK_EN defined, pressing btn_u[3] → call_u[3] stays 0.
